md_ctrl: RTL and testbench

Multiply/divide controller for the 5-stage pipeline. It owns the HI/LO register pair and sequences multi-cycle mult/multu/div/divu operations launched from the E stage. It serves mfhi/mflo reads and mthi/mtlo writes. It raises a stall toward the D stage whenever an HI/LO-related instruction would collide with an operation in flight.

---
 rtl/md_ctrl.sv | 94 +++++++++
 tb/tb_md_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_ctrl.sv
// md_ctrl: owns HI/LO, sequences multi-cycle mult/div from E, and stalls D on HI/LO hazards.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instr_FD,
  input  logic [31:0] Instr_DE,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MD_Out,
  output logic        Busy,
  output logic        Stall_MD
);
  localparam logic [3:0] ML = 4'(MULT_CYCLES);
  localparam logic [3:0] DL = 4'(DIV_CYCLES);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] ph, pl, ph_nx, pl_nx, hi_nx, lo_nx;
  logic [5:0]  fn;
  logic        md_de, mv_de, hl_fd, start, sgn, a_neg, b_neg;
  logic [63:0] prod;
  logic [31:0] ua, ub, uq, ur, q, r, res_h, res_l;
  logic        unused_bits;
  assign unused_bits = ^{Instr_FD[25:6], Instr_FD[1:0], Instr_DE[25:6]};
  assign fn    = Instr_DE[5:0];
  assign md_de = Instr_DE[31:26] == 6'd0 && fn[5:2] == 4'b0110;
  assign mv_de = Instr_DE[31:26] == 6'd0 && fn[5:2] == 4'b0100;
  assign hl_fd = Instr_FD[31:26] == 6'd0 && (Instr_FD[5:2] == 4'b0110 || Instr_FD[5:2] == 4'b0100);
  assign Busy     = state == RUN;
  assign start    = md_de && !Busy;
  assign Stall_MD = hl_fd && (start || Busy);
  assign MD_Out   = mv_de && !fn[0] ? (fn[1] ? LO : HI) : 32'd0;
  // func bit 0 selects the unsigned variant; signed division works on magnitudes
  assign sgn   = !fn[0];
  assign prod  = sgn ? {{32{A[31]}}, A} * {{32{B[31]}}, B} : {32'd0, A} * {32'd0, B};
  assign a_neg = sgn && A[31];
  assign b_neg = sgn && B[31];
  assign ua    = a_neg ? -A : A;
  assign ub    = b_neg ? -B : B;
  assign uq    = ua / (ub == 32'd0 ? 32'd1 : ub);
  assign ur    = ua % (ub == 32'd0 ? 32'd1 : ub);
  assign q     = a_neg ^ b_neg ? -uq : uq;
  assign r     = a_neg ? -ur : ur;
  assign res_h = fn[1] ? (B == 32'd0 ? A : r) : prod[63:32];
  assign res_l = fn[1] ? (B == 32'd0 ? 32'hFFFF_FFFF : q) : prod[31:0];
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ph_nx    = ph;
    pl_nx    = pl;
    hi_nx    = HI;
    lo_nx    = LO;
    if (state == IDLE) begin
      if (start) begin
        state_nx = RUN;
        cnt_nx   = fn[1] ? DL : ML;
        ph_nx    = res_h;
        pl_nx    = res_l;
      end else if (mv_de && fn[0]) begin
        hi_nx = fn[1] ? HI : A;
        lo_nx = fn[1] ? A : LO;
      end
    end else if (cnt == 4'd1) begin
      state_nx = IDLE;
      cnt_nx   = 4'd0;
      hi_nx    = ph;
      lo_nx    = pl;
    end else begin
      cnt_nx = cnt - 4'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ph    <= 32'd0;
      pl    <= 32'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ph    <= ph_nx;
      pl    <= pl_nx;
      HI    <= hi_nx;
      LO    <= lo_nx;
    end
  end
endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: randomized and directed checks of md_ctrl against an arithmetic HI/LO model.
module tb_md_ctrl;
  localparam int ML = 5;
  localparam int DL = 10;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010, F_MTLO = 6'b010011;
  logic clk = 0, rst_n = 0;
  logic [31:0] Instr_FD = 0, Instr_DE = 0, A = 0, B = 0;
  logic [31:0] HI, LO, MD_Out;
  logic Busy, Stall_MD;
  int total = 0, passed = 0;
  logic [31:0] hi_m = 0, lo_m = 0;

  md_ctrl #(.MULT_CYCLES(ML), .DIV_CYCLES(DL)) dut (
    .clk(clk), .rst_n(rst_n), .Instr_FD(Instr_FD), .Instr_DE(Instr_DE), .A(A), .B(B),
    .HI(HI), .LO(LO), .MD_Out(MD_Out), .Busy(Busy), .Stall_MD(Stall_MD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] f);
    logic [31:0] rnd;
    rnd = $urandom;
    return {6'd0, rnd[25:6], f};
  endfunction

  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, qq, rr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (f == F_MULT) return 64'(sa * sb);
    if (f == F_MULTU) return {32'd0, a} * {32'd0, b};
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (f == F_DIVU) return {a % b, a / b};
    qq = sa / sb;
    rr = sa % sb;
    return {rr[31:0], qq[31:0]};
  endfunction

  task automatic launch(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] fd, output int busy_n, output int stall_n, output bit held);
    logic [31:0] h0, l0;
    Instr_DE = mk(f); A = a; B = b; Instr_FD = fd;
    #1;
    h0 = HI; l0 = LO; busy_n = 0; held = 1; stall_n = int'(Stall_MD);
    total++;
    if (Busy !== 1'b0) $display("FAIL launch_idle: Busy=%b want 0", Busy); else passed++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      Instr_DE = 0; A = $urandom; B = $urandom;
      #1;
      if (!Busy) break;
      busy_n++;
      stall_n += int'(Stall_MD);
      if (HI !== h0 || LO !== l0) held = 0;
    end
    stall_n += int'(Stall_MD);
    Instr_FD = 0;
    {hi_m, lo_m} = model(f, a, b);
  endtask

  task automatic do_md(input string nm, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int bn, sn, lat;
    bit held;
    lat = f[1] ? DL : ML;
    launch(f, a, b, 32'd0, bn, sn, held);
    total++;
    if (bn !== lat) $display("FAIL %s_busy: cycles=%0d want %0d", nm, bn, lat); else passed++;
    total++;
    if (!held) $display("FAIL %s_held: HI/LO changed while busy", nm); else passed++;
    total++;
    if (HI !== hi_m) $display("FAIL %s_hi: got %h want %h", nm, HI, hi_m); else passed++;
    total++;
    if (LO !== lo_m) $display("FAIL %s_lo: got %h want %h", nm, LO, lo_m); else passed++;
  endtask

  task automatic test_reset;
    rst_n = 0; Instr_DE = mk(F_MFHI); Instr_FD = mk(F_MFLO);
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (HI !== 0 || LO !== 0) $display("FAIL reset_hilo: HI=%h LO=%h want 0", HI, LO); else passed++;
    total++;
    if (Busy !== 0 || Stall_MD !== 0) $display("FAIL reset_flags: Busy=%b Stall=%b want 0", Busy, Stall_MD); else passed++;
    total++;
    if (MD_Out !== 0) $display("FAIL reset_mdout: got %h want 0", MD_Out); else passed++;
    rst_n = 1; Instr_DE = 0; Instr_FD = 0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    do_md("multu", F_MULTU, 32'hFFFF_FFFF, 32'd2);
    do_md("div", F_DIV, -32'sd7, 32'd2);
    do_md("divu0", F_DIVU, 32'd5, 32'd0);
    do_md("div0", F_DIV, 32'hFFFF_FFF9, 32'd0);
    do_md("divovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    do_md("mult", F_MULT, -32'sd3, 32'd7);
  endtask

  task automatic test_stall;
    int bn, sn;
    bit held;
    launch(F_MULT, 32'd3, 32'd4, mk(F_MFLO), bn, sn, held);
    total++;
    if (sn !== ML + 1) $display("FAIL stall_len: cycles=%0d want %0d", sn, ML + 1); else passed++;
    Instr_DE = mk(F_MFLO);
    #1;
    total++;
    if (MD_Out !== 32'd12) $display("FAIL stall_mflo: got %h want 0000000c", MD_Out); else passed++;
    @(negedge clk);
    Instr_DE = 0;
  endtask

  task automatic test_move;
    Instr_DE = mk(F_MTHI); A = 32'hDEAD_BEEF;
    #1;
    total++;
    if (MD_Out !== 0) $display("FAIL mthi_mdout: got %h want 0", MD_Out); else passed++;
    @(negedge clk);
    Instr_DE = mk(F_MFHI); A = $urandom;
    #1;
    total++;
    if (MD_Out !== 32'hDEAD_BEEF) $display("FAIL mfhi_after_mthi: got %h want deadbeef", MD_Out); else passed++;
    hi_m = 32'hDEAD_BEEF;
    @(negedge clk);
    Instr_DE = 0;
  endtask

  task automatic test_move_busy;
    logic [31:0] h0;
    int bn;
    h0 = HI;
    Instr_DE = mk(F_MULT); A = 32'h0001_2345; B = 32'hFFFF_0003;
    #1;
    @(negedge clk);
    Instr_DE = mk(F_MTHI); A = 32'h1234_5678;
    #1;
    total++;
    if (Busy !== 1) $display("FAIL mvbusy_busy: Busy=%b want 1", Busy); else passed++;
    @(negedge clk);
    Instr_DE = mk(F_MULTU); A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    #1;
    total++;
    if (HI !== h0) $display("FAIL mvbusy_ignored: HI=%h want %h", HI, h0); else passed++;
    bn = 2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      Instr_DE = 0;
      #1;
      if (!Busy) break;
      bn++;
    end
    {hi_m, lo_m} = model(F_MULT, 32'h0001_2345, 32'hFFFF_0003);
    total++;
    if (bn !== ML) $display("FAIL mvbusy_len: cycles=%0d want %0d", bn, ML); else passed++;
    total++;
    if (HI !== hi_m || LO !== lo_m) $display("FAIL mvbusy_commit: got %h_%h want %h_%h", HI, LO, hi_m, lo_m); else passed++;
  endtask

  task automatic test_back_to_back;
    do_md("b2b_first", F_MULTU, 32'h89AB_CDEF, 32'h0F0F_0F0F);
    do_md("b2b_second", F_DIVU, 32'hFFFF_FFF0, 32'd13);
  endtask

  task automatic test_reset_mid;
    bit bad;
    Instr_DE = mk(F_DIV); A = 32'd100; B = 32'd7;
    #1;
    repeat (3) begin
      @(negedge clk);
      Instr_DE = 0;
    end
    #2;
    Instr_FD = mk(F_MFHI); Instr_DE = mk(F_MFLO);
    #1;
    rst_n = 0;
    #1;
    total++;
    if (Busy !== 0 || Stall_MD !== 0) $display("FAIL rstmid_flags: Busy=%b Stall=%b want 0", Busy, Stall_MD); else passed++;
    total++;
    if (HI !== 0 || LO !== 0 || MD_Out !== 0) $display("FAIL rstmid_clear: HI=%h LO=%h MD_Out=%h want 0", HI, LO, MD_Out); else passed++;
    @(negedge clk);
    rst_n = 1; Instr_FD = 0; Instr_DE = 0; hi_m = 0; lo_m = 0; bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      #1;
      if (Busy || HI !== 0 || LO !== 0) bad = 1;
    end
    total++;
    if (bad) $display("FAIL rstmid_nocommit: HI=%h LO=%h after reset", HI, LO); else passed++;
  endtask

  task automatic test_random;
    logic [5:0] fl[9];
    logic [31:0] a, b, fd, x;
    int k, bn, sn, lat;
    bit held, hz;
    fl = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_MFHI, F_MFLO, F_MULT};
    for (int it = 0; it < 60; it++) begin
      k = $urandom_range(0, 8);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = $urandom_range(1, 9);
        2: b = -$urandom_range(1, 9);
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      if (k == 8) begin
        x = $urandom;
        Instr_DE = {6'b100011, x[25:6], F_MULT}; Instr_FD = mk(F_MFHI); A = a; B = b;
        #1;
        total++;
        if (Stall_MD !== 0) $display("FAIL rnd_inert_stall: got %b want 0", Stall_MD); else passed++;
        @(negedge clk);
        Instr_DE = 0; Instr_FD = 0;
        #1;
        total++;
        if (Busy !== 0 || HI !== hi_m || LO !== lo_m) $display("FAIL rnd_inert: Busy=%b HI=%h LO=%h want 0 %h %h", Busy, HI, LO, hi_m, lo_m); else passed++;
      end else if (k < 4) begin
        hz = $urandom_range(0, 1);
        fd = hz ? mk(fl[$urandom_range(4, 7)]) : 32'd0;
        lat = fl[k][1] ? DL : ML;
        launch(fl[k], a, b, fd, bn, sn, held);
        total++;
        if (bn !== lat || sn !== (hz ? lat + 1 : 0)) $display("FAIL rnd_timing f=%b: busy=%0d stall=%0d want %0d %0d", fl[k], bn, sn, lat, hz ? lat + 1 : 0); else passed++;
        total++;
        if (HI !== hi_m || LO !== lo_m) $display("FAIL rnd_result f=%b a=%h b=%h: got %h_%h want %h_%h", fl[k], a, b, HI, LO, hi_m, lo_m); else passed++;
      end else begin
        Instr_DE = mk(fl[k]); A = a;
        #1;
        x = fl[k] == F_MFHI ? hi_m : fl[k] == F_MFLO ? lo_m : 32'd0;
        total++;
        if (MD_Out !== x) $display("FAIL rnd_mdout f=%b: got %h want %h", fl[k], MD_Out, x); else passed++;
        if (fl[k] == F_MTHI) hi_m = a;
        if (fl[k] == F_MTLO) lo_m = a;
        @(negedge clk);
        Instr_DE = 0;
        #1;
        total++;
        if (HI !== hi_m || LO !== lo_m) $display("FAIL rnd_move f=%b: got %h_%h want %h_%h", fl[k], HI, LO, hi_m, lo_m); else passed++;
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_directed;
    test_stall;
    test_move;
    test_move_busy;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
